// File: rtl/periph_arb_pkg.sv
// Shared types and constants for the two-master peripheral bus arbiter.
// Imported by periph_arb and rr_pick2.
package periph_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        ACK  = 2'd2
    } state_t;

    localparam logic M_CPU = 1'b0;
    localparam logic M_DMA = 1'b1;

    localparam int TIMEOUT_CYC_DEF = 255;

    function automatic logic [1:0] onehot2(input logic idx);
        return (idx == M_DMA) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin selector with a lock override for read-modify-write sequences.
// Purely combinational; the caller registers the result.
module rr_pick2
    import periph_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    input  logic       lock_hold,
    output logic       winner,
    output logic       valid
);

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        winner = M_CPU;
        valid  = |req;
        if (lock_hold && req[last]) begin
            winner = last;
        end else if (&req) begin
            winner = ~last;
        end else if (req[M_DMA]) begin
            winner = M_DMA;
        end
    end

endmodule

// File: rtl/periph_arb.sv
// Two-master arbiter in front of the shared peripheral bus: round-robin with lock,
// one transaction in flight, registered bus side. Optional abort timer: PARB_TIMEOUT_EN.
module periph_arb
    import periph_arb_pkg::*;
#(
    parameter int AW          = 16,
    parameter int DW          = 16,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          m0_req,
    input  logic          m0_we,
    input  logic          m0_lock,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic [DW-1:0] m0_rdata,
    output logic          m0_ack,
    output logic          m0_err,

    input  logic          m1_req,
    input  logic          m1_we,
    input  logic          m1_lock,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic [DW-1:0] m1_rdata,
    output logic          m1_ack,
    output logic          m1_err,

    output logic          bus_sel,
    output logic          bus_we,
    output logic          bus_re,
    output logic [AW-1:0] bus_addr,
    output logic [DW-1:0] bus_wdata,
    input  logic [DW-1:0] bus_rdata,
    input  logic          bus_rdy,

    output logic [1:0]    gnt
);

    if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535) begin : g_bad_timeout
        $error("periph_arb: TIMEOUT_CYC must be within 1..65535");
    end

    state_t        state;
    logic          last;
    logic          cur;
    logic          lock_hold;
    logic          pick_win;
    logic          pick_valid;
    logic          sel_we;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;
    logic          tmo_hit;
    logic          done;

    rr_pick2 u_pick (
        .req       ({m1_req, m0_req}),
        .last      (last),
        .lock_hold (lock_hold),
        .winner    (pick_win),
        .valid     (pick_valid)
    );

    assign sel_we    = (pick_win == M_DMA) ? m1_we    : m0_we;
    assign sel_addr  = (pick_win == M_DMA) ? m1_addr  : m0_addr;
    assign sel_wdata = (pick_win == M_DMA) ? m1_wdata : m0_wdata;

    // A ready arriving in the same cycle as the timeout wins, so done never reports an error then.
    assign done = (state == BUSY) && (bus_rdy || tmo_hit);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            last      <= M_DMA;
            cur       <= M_CPU;
            lock_hold <= 1'b0;
            bus_sel   <= 1'b0;
            bus_we    <= 1'b0;
            bus_re    <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            m0_rdata  <= '0;
            m1_rdata  <= '0;
            m0_ack    <= 1'b0;
            m1_ack    <= 1'b0;
            gnt       <= 2'b00;
        end else begin
            // NOTE: state registers use non-blocking assignments so every read sees the pre-edge value.
            case (state)
                IDLE: begin
                    lock_hold <= 1'b0;
                    if (pick_valid) begin
                        cur       <= pick_win;
                        last      <= pick_win;
                        bus_sel   <= 1'b1;
                        bus_we    <= sel_we;
                        bus_re    <= ~sel_we;
                        bus_addr  <= sel_addr;
                        bus_wdata <= sel_wdata;
                        gnt       <= onehot2(pick_win);
                        state     <= BUSY;
                    end
                end
                BUSY: begin
                    if (done) begin
                        bus_sel   <= 1'b0;
                        bus_we    <= 1'b0;
                        bus_re    <= 1'b0;
                        bus_addr  <= '0;
                        bus_wdata <= '0;
                        if (cur == M_DMA) begin
                            m1_ack <= 1'b1;
                            if (tmo_hit)      m1_rdata <= '0;
                            else if (!bus_we) m1_rdata <= bus_rdata;
                        end else begin
                            m0_ack <= 1'b1;
                            if (tmo_hit)      m0_rdata <= '0;
                            else if (!bus_we) m0_rdata <= bus_rdata;
                        end
                        state <= ACK;
                    end
                end
                ACK: begin
                    m0_ack    <= 1'b0;
                    m1_ack    <= 1'b0;
                    gnt       <= 2'b00;
                    lock_hold <= (cur == M_DMA) ? m1_lock : m0_lock;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef PARB_TIMEOUT_EN
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYC - 1);

    logic [15:0] tmo_cnt;

    // Counter sits at zero throughout IDLE, so it is clear on every BUSY entry.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tmo_cnt <= '0;
        end else if (state != BUSY) begin
            tmo_cnt <= '0;
        end else if (!bus_rdy) begin
            tmo_cnt <= tmo_cnt + 16'd1;
        end
    end

    assign tmo_hit = (state == BUSY) && !bus_rdy && (tmo_cnt == TMO_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            m0_err <= 1'b0;
            m1_err <= 1'b0;
        end else if (tmo_hit) begin
            m0_err <= (cur == M_CPU);
            m1_err <= (cur == M_DMA);
        end else if (state == ACK) begin
            m0_err <= 1'b0;
            m1_err <= 1'b0;
        end
    end
`else
    assign tmo_hit = 1'b0;
    assign m0_err  = 1'b0;
    assign m1_err  = 1'b0;
`endif

endmodule
